keypad_scanner: RTL

- Parametrised matrix-keypad scanner; successor to the fixed 4x4 combinational-decode scanner.
- Drives one row at a time, samples columns through synchronisers and debounces whole scan frames.
- Reports press and release events through a small FIFO with a valid/ready handshake.
- Sits between the keypad pins and game-control logic (paddle input, menu).

---
 rtl/keypad_scanner.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Row-scanned matrix keypad with whole-frame debounce and press/release event FIFO.
// Optional `KEYPAD_AUTOREPEAT_EN adds held-key repeat press events.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_FRAMES = 30
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [ROWS-1:0]               row_out,
  input  logic [COLS-1:0]               col_in,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  ev_code,
  output logic                          ev_release,
  output logic                          key_down,
  output logic                          overflow
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    EMIT
  } emit_st_t;

  logic [COLS-1:0] col_s1, col_s2;
  logic [RW-1:0]   row_idx, row_d1, row_d2;
  logic [DW-1:0]   div;
  logic            strb_d1, strb_d2;
  logic            last;
  logic            frame_end;

  logic [N-1:0]    frame, frame_nxt;
  logic [N-1:0]    prev_frame;
  logic [N-1:0]    stable;
  logic [BW-1:0]   cnt, cnt_nxt;
  logic            upd;

  emit_st_t        st;
  logic [N-1:0]    diff;
  logic [N-1:0]    old;
  logic [CW-1:0]   lo_code;
  logic            push_v;
  logic [CW-1:0]   push_code;
  logic            push_rel;

  logic [CW-1:0]   mem_code [FIFO_DEPTH];
  logic            mem_rel  [FIFO_DEPTH];
  logic [AW:0]     wp, rp;
  logic            full, empty, pop, do_push;

  assign row_out   = ROWS'(1) << row_idx;
  assign last      = (div == DW'(SCAN_DIV - 1));
  assign frame_end = strb_d2 && (row_d2 == RW'(ROWS - 1));

  // The sample strobe and its row tag ride alongside the synchroniser,
  // so each row's columns land in the frame slot of the row that drove them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1  <= '0;
      col_s2  <= '0;
      row_idx <= '0;
      div     <= '0;
      strb_d1 <= 1'b0;
      strb_d2 <= 1'b0;
      row_d1  <= '0;
      row_d2  <= '0;
      frame   <= '0;
    end else begin
      col_s1  <= col_in;
      col_s2  <= col_s1;
      strb_d1 <= last;
      row_d1  <= row_idx;
      strb_d2 <= strb_d1;
      row_d2  <= row_d1;
      if (last) begin
        div     <= '0;
        row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      if (strb_d2) frame <= frame_nxt;
    end
  end

  always_comb begin
    frame_nxt = frame;
    frame_nxt[row_d2*COLS +: COLS] = col_s2;
  end

  always_comb begin
    if (frame_nxt == prev_frame)
      cnt_nxt = (cnt == BW'(DEBOUNCE)) ? cnt : cnt + 1'b1;
    else
      cnt_nxt = BW'(1);
  end

  assign upd = frame_end && (cnt_nxt == BW'(DEBOUNCE)) &&
               (frame_nxt != stable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_frame <= '0;
      cnt        <= '0;
      stable     <= '0;
      key_down   <= 1'b0;
    end else begin
      key_down <= |stable;
      if (frame_end) begin
        prev_frame <= frame_nxt;
        cnt        <= cnt_nxt;
        if (upd) stable <= frame_nxt;
      end
    end
  end

  always_comb begin
    lo_code = '0;
    for (int i = N - 1; i >= 0; i--)
      if (diff[i]) lo_code = CW'(i);
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_FRAMES + 1);

  logic [RPW-1:0] rep_cnt;
  logic [CW-1:0]  stable_code;
  logic           one_held;
  logic           rep_fire;

  always_comb begin
    stable_code = '0;
    for (int i = N - 1; i >= 0; i--)
      if (stable[i]) stable_code = CW'(i);
  end

  assign one_held = $onehot(stable);
  assign rep_fire = frame_end && !upd && one_held &&
                    (rep_cnt == RPW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (frame_end) begin
      if (upd || !one_held || rep_fire)
        rep_cnt <= '0;
      else
        rep_cnt <= rep_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      diff      <= '0;
      old       <= '0;
      push_v    <= 1'b0;
      push_code <= '0;
      push_rel  <= 1'b0;
    end else begin
      push_v <= 1'b0;
      unique case (st)
        IDLE: begin
          if (upd) begin
            diff <= stable ^ frame_nxt;
            old  <= stable;
            st   <= EMIT;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_fire) begin
            push_v    <= 1'b1;
            push_code <= stable_code;
            push_rel  <= 1'b0;
          end
`endif
        end
        EMIT: begin
          push_v    <= 1'b1;
          push_code <= lo_code;
          push_rel  <= old[lo_code];
          // clear the lowest set bit; done once nothing remains
          diff      <= diff & (diff - 1'b1);
          if ((diff & (diff - 1'b1)) == '0) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign ev_valid = !empty;
  assign pop      = ev_valid && ev_ready;
  assign do_push  = push_v && (!full || pop);

  assign ev_code    = mem_code[rp[AW-1:0]];
  assign ev_release = mem_rel[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_code[i] <= '0;
        mem_rel[i]  <= 1'b0;
      end
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_v && full && !pop;
      if (do_push) begin
        mem_code[wp[AW-1:0]] <= push_code;
        mem_rel[wp[AW-1:0]]  <= push_rel;
        wp                   <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

endmodule
